// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller: synchronized edge-triggered sources, PEND/MASK/VEC/CTRL
// window at BASE, level irq and stretched nmi pulse. Define IRQ_CTRL_PRIORITY_EN for the VEC encoder.
module irq_controller #(
    parameter logic [15:0] BASE       = 16'hD000,
    parameter int          NMI_CYCLES = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] addr,
    input  logic [7:0]  wr_data,
    input  logic        wr_en,
    output logic [7:0]  rd_data,
    output logic        rd_sel,
    input  logic [7:0]  src,
    input  logic        nmi_src,
    output logic        irq,
    output logic        nmi
);

    localparam logic [3:0] NMI_LOAD = 4'(NMI_CYCLES);

`ifdef IRQ_CTRL_PRIORITY_EN
    function automatic logic [7:0] prio_vec(input logic [7:0] act);
        logic [7:0] v;
        v = 8'h80;
        for (int i = 7; i >= 0; i--) begin
            if (act[i]) v = {5'b0, 3'(i)};
        end
        return v;
    endfunction
`endif

    logic [8:0]  sync_p0, sync_p1, edge_p2;
    logic [1:0]  arm;
    logic [8:0]  rise;
    logic [15:0] off;
    logic        in_win, wr_hit, rd_hit;
    logic [7:0]  clr;
    logic [7:0]  pending, mask;
    logic        gen;
    logic [3:0]  nmi_cnt, nmi_cnt_next;
    logic        rd_vld_p0;
    logic [1:0]  rd_off_p0;
    logic [7:0]  vec, rd_mux;

    // Stage boundary: synchronizer (p0, p1) and edge-history flop (p2)
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            edge_p2 <= '0;
            arm     <= '0;
        end else begin
            sync_p0 <= {nmi_src, src};
            sync_p1 <= sync_p0;
            edge_p2 <= sync_p1;
            if (arm != 2'd3) arm <= arm + 2'd1;
        end
    end

    // Inputs already high when reset drops look like rises until the pipeline fills; ignore them.
    assign rise   = (arm == 2'd3) ? (sync_p1 & ~edge_p2) : '0;

    assign off    = addr - BASE;
    assign in_win = (off < 16'd4);
    assign wr_hit = wr_en & in_win;
    assign rd_hit = ~wr_en & in_win;
    assign clr    = (wr_hit && off[1:0] == 2'd0) ? wr_data : 8'h00;

`ifdef IRQ_CTRL_PRIORITY_EN
    assign vec = prio_vec(pending & mask);
`else
    assign vec = 8'h00;
`endif

    always_comb begin
        nmi_cnt_next = nmi_cnt;
        if (rise[8])              nmi_cnt_next = NMI_LOAD;
        else if (nmi_cnt != 4'd0) nmi_cnt_next = nmi_cnt - 4'd1;
    end

    always_comb begin
        rd_mux = 8'h00;
        case (rd_off_p0)
            2'd0:    rd_mux = pending;
            2'd1:    rd_mux = mask;
            2'd2:    rd_mux = vec;
            default: rd_mux = {7'b0, gen};
        endcase
    end

    // Stage boundary: register file, irq/nmi outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending <= '0;
            mask    <= '0;
            gen     <= 1'b0;
            irq     <= 1'b0;
            nmi_cnt <= '0;
            nmi     <= 1'b0;
        end else begin
            pending <= (pending & ~clr) | rise[7:0];
            if (wr_hit && off[1:0] == 2'd1) mask <= wr_data;
            if (wr_hit && off[1:0] == 2'd3) gen  <= wr_data[0];
            irq     <= gen & |(pending & mask);
            nmi_cnt <= nmi_cnt_next;
            nmi     <= (nmi_cnt_next != 4'd0);
        end
    end

    // Stage boundary: read decode (p0) then registered read data
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_vld_p0 <= 1'b0;
            rd_off_p0 <= '0;
            rd_sel    <= 1'b0;
            rd_data   <= '0;
        end else begin
            rd_vld_p0 <= rd_hit;
            rd_off_p0 <= off[1:0];
            rd_sel    <= rd_vld_p0;
            rd_data   <= rd_vld_p0 ? rd_mux : 8'h00;
        end
    end

endmodule

// File: doc/irq_controller.md
IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 Parameter BASE, default 16'hD000: base address of the 4-byte register window.
REQ-002 Parameter NMI_CYCLES, default 4: width of the nmi output pulse in clocks, legal range 1..15.
REQ-003 clock  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 addr  input  16  CPU address bus.
REQ-006 wr_data  input  8  CPU write data, from CPU dout.
REQ-007 wr_en  input  1  CPU write strobe, active-high.
REQ-008 rd_data  output  8  registered read data, muxed into CPU din.
REQ-009 rd_sel  output  1  registered; high when rd_data is valid this cycle for the bus mux.
REQ-010 src  input  8  asynchronous peripheral interrupt requests, rising-edge sensitive.
REQ-011 nmi_src  input  1  asynchronous non-maskable request, rising-edge sensitive.
REQ-012 irq  output  1  registered, active-high level to the CPU irq input.
REQ-013 nmi  output  1  registered, active-high pulse to the CPU nmi input.

Function
REQ-014 Each src bit and nmi_src SHALL pass through a 2-flop synchronizer, then a third flop for edge detection; a 0->1 transition on the synchronized signal is one edge event.
REQ-015 Registers SHALL be at offsets from BASE:
- +0 PEND: read returns pending[7:0]; write-1-to-clear.
- +1 MASK: read/write.
- +2 VEC: read-only.
- +3 CTRL: bit0 GEN (global enable); other bits read 0.
REQ-016 A src[i] edge event SHALL set pending[i] regardless of MASK or GEN.
REQ-017 A set event and a write-1-to-clear on the same bit in the same cycle SHALL leave the bit set.
REQ-018 irq SHALL be registered as GEN & |(pending & MASK); it updates one clock after any change to its inputs.
REQ-019 Latency: a src rise sampled at edge k SHALL give pending set at k+2 and irq high at k+3.
REQ-020 A nmi_src edge event SHALL load a 4-bit counter with NMI_CYCLES; nmi SHALL be high exactly while the counter is nonzero.
REQ-021 A nmi_src edge event while the counter is nonzero SHALL reload the counter, extending the pulse, not doubling it.
REQ-022 On a read, when addr is within BASE..BASE+3 and wr_en is 0 at edge k, rd_data and rd_sel SHALL be valid after edge k+1; otherwise rd_sel is 0 and rd_data is 8'h00.
REQ-023 Writes SHALL take effect at the edge where wr_en is high and addr is in the window; writes to VEC are ignored.
REQ-024 Addresses outside the window SHALL have no effect on any state.

Reset
REQ-025 While reset is high, all of the following SHALL be 0: pending, MASK, GEN, synchronizer and edge flops, NMI counter, irq, nmi, rd_data, rd_sel.
REQ-026 Reset asserted mid-pulse SHALL terminate nmi immediately (asynchronously).
REQ-027 Edges in flight at reset deassertion SHALL be discarded.

Configuration
REQ-028 Macro IRQ_CTRL_PRIORITY_EN defined: VEC SHALL read {1'b0, 4'b0, n}, where n is the lowest-numbered bit of pending & MASK; with no such bit, VEC reads 8'h80.
REQ-029 Macro IRQ_CTRL_PRIORITY_EN undefined: the priority encoder SHALL be absent and VEC SHALL read 8'h00; all other behaviour is unchanged.

Verification
REQ-030 Reset with src=8'hFF held high -> irq=0, nmi=0, PEND reads 8'h00 after reset release, since there is no edge.
REQ-031 Write MASK=8'h04 and CTRL=8'h01, pulse src[2] at edge k -> pending=8'h04 at k+2 and irq=1 at k+3; write PEND=8'h04 -> irq=0 one clock after the write edge.
REQ-032 MASK=8'h00, pulse src[5] -> PEND reads 8'h20 and irq stays 0; then write MASK=8'h20 with GEN=1 -> irq=1 next clock.
REQ-033 Same-cycle src[1] edge event and PEND write 8'h02 -> pending[1] remains 1.
REQ-034 nmi_src pulse -> nmi high for exactly 4 clocks; a second edge at pulse clock 2 -> nmi high 4 clocks from the reload, with no gap.
REQ-035 With IRQ_CTRL_PRIORITY_EN defined, pending=8'h28 and MASK=8'hFF -> VEC reads 8'h03; MASK=8'h00 -> 8'h80; with the macro undefined -> 8'h00.
